multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Parametrised multi-cycle successor to the single-cycle CPU decoder.
- Moore FSM that sequences FETCH/DECODE/EXEC/MEM/WB over several clocks, supports memory wait states via a ready handshake and adds ADDI/BNE.
- Provides single-step gating for the hand-clock debug flow, an instruction counter, and instruction-type LED flags.
- Sits between the IR opcode field and the multi-cycle datapath muxes/enables in the CPU top.

Parameters:
- CNT_W, 8, width of the retired-instruction counter.
- TRAP_ON_ILLEGAL, 1, 1 = halt in ILLEGAL until reset; 0 = flag and skip to FETCH.
- EXT_EN, 1, 1 = decode ADDI (001000) and BNE (000101); 0 = treat them as illegal.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- step_en  in  1  advance enable; 0 freezes the FSM and suppresses all write strobes
- opcode  in  6  IR[31:26]
- mem_ready  in  1  memory completes the current MemRead/MemWrite this cycle
- PCWrite, PCWriteCond, PCWriteCondNe, IRWrite, RegWrite  out  1 each  single-cycle write strobes
- MemRead, MemWrite  out  1  level requests
- IorD, ALUSrcA, RegDst, MemtoReg  out  1  mux selects
- ALUSrcB  out  2  00 B, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 funct
- PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target
- state  out  4  current state, for debug display
- instr_done  out  1  one-cycle pulse on instruction retire
- instr_count  out  CNT_W  retired-instruction count
- illegal  out  1  sticky illegal-opcode flag
- J, R, LW, SW, BEQ  out  1 each  registered type of the current instruction (BEQ is also set for BNE)

Behaviour:
- Reset (synchronous, dominant over step_en):
  - state = FETCH (0); instr_count = 0; illegal = 0; type flags = 0.
  - All strobes and MemRead/MemWrite are 0 in the reset cycle; selects take their FETCH values.
- adv = step_en & (state not in {FETCH, MEM_READ, MEM_WRITE} | mem_ready).
  - The state register and the type flags update only when adv = 1.
- Strobes (PCWrite, PCWriteCond, PCWriteCondNe, IRWrite, RegWrite) are asserted only in a cycle where adv = 1.
- MemRead/MemWrite are held for the whole dwell of their state, independent of step_en.
- States and outputs; unlisted outputs are 0:
  - FETCH 0: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite, PCWrite strobed. -> DECODE.
  - DECODE 1: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Latch type flags. Next state by opcode:
    - 000000 -> R_EXEC
    - 100011 / 101011 -> MEM_ADDR
    - 000100 / 000101 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDI_EXEC
    - any other -> ILLEGAL
  - MEM_ADDR 2: ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> MEM_READ (lw) or MEM_WRITE (sw).
  - MEM_READ 3: MemRead, IorD=1. -> MEM_WB.
  - MEM_WB 4: RegDst=0, MemtoReg=1, RegWrite. -> FETCH, retire.
  - MEM_WRITE 5: MemWrite, IorD=1. -> FETCH, retire.
  - R_EXEC 6: ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> R_WB.
  - R_WB 7: RegDst=1, MemtoReg=0, RegWrite. -> FETCH, retire.
  - BRANCH 8: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01. Strobe PCWriteCond (beq) or PCWriteCondNe (bne). -> FETCH, retire.
  - JUMP 9: PCSource=10, PCWrite. -> FETCH, retire.
  - ADDI_EXEC 10: ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> ADDI_WB.
  - ADDI_WB 11: RegDst=0, MemtoReg=0, RegWrite. -> FETCH, retire.
  - ILLEGAL 12:
    - illegal is set on entry.
    - TRAP_ON_ILLEGAL=1: stay in ILLEGAL, all strobes 0, until reset.
    - TRAP_ON_ILLEGAL=0: one cycle -> FETCH with no retire (PC was already advanced in FETCH, so the instruction is skipped).
- Retire: instr_done = adv on any retiring transition; instr_count increments on the same edge and wraps 2^CNT_W-1 -> 0.
- Latencies (cycles with step_en=1, mem_ready=1):
  - lw: 5
  - sw, R, addi: 4
  - beq/bne, j: 3
  - Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- mem_ready is ignored outside the three memory states.
- step_en=0 while mem_ready=1: the FSM holds and the request stays asserted; memory must tolerate repeated reads.
- State codes 13-15 are unreachable; if entered, go to FETCH on the next adv.

Decomposition:
- Shared package (mc_pkg) holds:
  - state encodings (4-bit localparams)
  - opcode constants: OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI
  - ALUOp codes, ALUSrcB codes, PCSource codes
- One combinational sub-module, mc_output_decode (state -> mux selects / raw strobes), is natural.
- The FSM register, adv gating, counter and flags stay in the top.

Test Plan:
- Reset mid-MEM_READ with mem_ready=0 -> next cycle state=0, instr_count=0, MemRead=1 (FETCH), no RegWrite.
- lw (100011) with mem_ready=1 constantly -> states 0,1,2,3,4; RegWrite+MemtoReg=1 in cycle 5; instr_done pulses once; instr_count=1.
- sw with mem_ready held 0 for 3 cycles in MEM_WRITE -> MemWrite high for 4 cycles, state 5 for 4 cycles, total latency 7.
- Sequence beq, bne, j, addi, R -> PCWriteCond only in beq's state 8, PCWriteCondNe only in bne's; PCSource=10 with PCWrite in j; RegDst=0 for addi, 1 for R; instr_count=5.
- Opcode 111111:
  - TRAP_ON_ILLEGAL=1 -> illegal=1, state=12 held for 20 cycles, no strobes.
  - TRAP_ON_ILLEGAL=0 -> state 12 for one cycle, then state 0, instr_count unchanged.
- step_en toggled 1/0 every cycle through an R instruction; CNT_W=2 with 5 retirements -> latency doubles to 8 with strobes only on step_en=1 cycles; instr_count wraps 3 -> 0 -> 1.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: state codes, opcodes,
// datapath mux codes and the control bundle driven by the output decoder.
package mc_pkg;

  localparam logic [3:0] ST_FETCH     = 4'd0;
  localparam logic [3:0] ST_DECODE    = 4'd1;
  localparam logic [3:0] ST_MEM_ADDR  = 4'd2;
  localparam logic [3:0] ST_MEM_READ  = 4'd3;
  localparam logic [3:0] ST_MEM_WB    = 4'd4;
  localparam logic [3:0] ST_MEM_WRITE = 4'd5;
  localparam logic [3:0] ST_R_EXEC    = 4'd6;
  localparam logic [3:0] ST_R_WB      = 4'd7;
  localparam logic [3:0] ST_BRANCH    = 4'd8;
  localparam logic [3:0] ST_JUMP      = 4'd9;
  localparam logic [3:0] ST_ADDI_EXEC = 4'd10;
  localparam logic [3:0] ST_ADDI_WB   = 4'd11;
  localparam logic [3:0] ST_ILLEGAL   = 4'd12;

  typedef enum logic [3:0] {
    S_FETCH     = ST_FETCH,
    S_DECODE    = ST_DECODE,
    S_MEM_ADDR  = ST_MEM_ADDR,
    S_MEM_READ  = ST_MEM_READ,
    S_MEM_WB    = ST_MEM_WB,
    S_MEM_WRITE = ST_MEM_WRITE,
    S_R_EXEC    = ST_R_EXEC,
    S_R_WB      = ST_R_WB,
    S_BRANCH    = ST_BRANCH,
    S_JUMP      = ST_JUMP,
    S_ADDI_EXEC = ST_ADDI_EXEC,
    S_ADDI_WB   = ST_ADDI_WB,
    S_ILLEGAL   = ST_ILLEGAL
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       alu_src_a;
    logic       reg_dst;
    logic       memto_reg;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_ne;
    logic       ir_write;
    logic       reg_write;
  } ctrl_t;

  // States that wait on mem_ready before they may advance.
  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

  function automatic logic is_retire_state(input state_e s);
    return (s == S_MEM_WB) || (s == S_MEM_WRITE) || (s == S_R_WB) ||
           (s == S_BRANCH) || (s == S_JUMP) || (s == S_ADDI_WB);
  endfunction

  function automatic state_e decode_op(input logic [5:0] op, input bit ext_en);
    case (op)
      OP_R:         return S_R_EXEC;
      OP_LW, OP_SW: return S_MEM_ADDR;
      OP_BEQ:       return S_BRANCH;
      OP_BNE:       return ext_en ? S_BRANCH : S_ILLEGAL;
      OP_J:         return S_JUMP;
      OP_ADDI:      return ext_en ? S_ADDI_EXEC : S_ILLEGAL;
      default:      return S_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode: state -> datapath mux selects, memory requests and
// ungated write strobes. Strobe gating by the advance condition is done by the top.
module mc_output_decode
  import mc_pkg::*;
(
  input  state_e state,
  input  logic   is_bne,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.memto_reg = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a        = 1'b1;
        ctrl.alu_src_b        = SRCB_B;
        ctrl.alu_op           = ALUOP_SUB;
        ctrl.pc_source        = PCSRC_ALUOUT;
        ctrl.pc_write_cond    = ~is_bne;
        ctrl.pc_write_cond_ne = is_bne;
      end
      S_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle CPU control FSM with memory wait states, single-step gating,
// retired-instruction counter and instruction-type flags.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int CNT_W           = 8,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter bit EXT_EN          = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step_en,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             PCWriteCondNe,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             ALUSrcA,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal,
  output logic             J,
  output logic             R,
  output logic             LW,
  output logic             SW,
  output logic             BEQ
);

  state_e st_q;
  state_e dec_state;
  state_e dec_nxt;
  ctrl_t  raw;
  logic   bne_q;
  logic   adv;
  logic   retire;
  logic   gate;
  logic   op_bne;

  assign adv     = step_en & (~is_mem_state(st_q) | mem_ready);
  assign retire  = adv & is_retire_state(st_q);
  assign gate    = adv & ~reset;
  assign dec_nxt = decode_op(opcode, EXT_EN);
  assign op_bne  = EXT_EN && (opcode == OP_BNE);

  // During the reset cycle the selects already show FETCH, with requests muted.
  assign dec_state = reset ? S_FETCH : st_q;

  mc_output_decode u_dec (
    .state  (dec_state),
    .is_bne (bne_q),
    .ctrl   (raw)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q        <= S_FETCH;
      instr_count <= '0;
      illegal     <= 1'b0;
      bne_q       <= 1'b0;
      J           <= 1'b0;
      R           <= 1'b0;
      LW          <= 1'b0;
      SW          <= 1'b0;
      BEQ         <= 1'b0;
    end else begin
      if (retire) instr_count <= instr_count + CNT_W'(1);
      if (adv) begin
        case (st_q)
          S_FETCH:     st_q <= S_DECODE;
          S_DECODE: begin
            st_q  <= dec_nxt;
            R     <= (opcode == OP_R);
            LW    <= (opcode == OP_LW);
            SW    <= (opcode == OP_SW);
            J     <= (opcode == OP_J);
            BEQ   <= (opcode == OP_BEQ) | op_bne;
            bne_q <= op_bne;
            if (dec_nxt == S_ILLEGAL) illegal <= 1'b1;
          end
          S_MEM_ADDR:  st_q <= LW ? S_MEM_READ : S_MEM_WRITE;
          S_MEM_READ:  st_q <= S_MEM_WB;
          S_R_EXEC:    st_q <= S_R_WB;
          S_ADDI_EXEC: st_q <= S_ADDI_WB;
          // Non-trapping mode skips the instruction: PC already moved in FETCH.
          S_ILLEGAL:   st_q <= TRAP_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
          default:     st_q <= S_FETCH;
        endcase
      end
    end
  end

  assign PCWrite       = raw.pc_write & gate;
  assign PCWriteCond   = raw.pc_write_cond & gate;
  assign PCWriteCondNe = raw.pc_write_cond_ne & gate;
  assign IRWrite       = raw.ir_write & gate;
  assign RegWrite      = raw.reg_write & gate;
  assign MemRead       = raw.mem_read & ~reset;
  assign MemWrite      = raw.mem_write & ~reset;
  assign IorD          = raw.iord;
  assign ALUSrcA       = raw.alu_src_a;
  assign RegDst        = raw.reg_dst;
  assign MemtoReg      = raw.memto_reg;
  assign ALUSrcB       = raw.alu_src_b;
  assign ALUOp         = raw.alu_op;
  assign PCSource      = raw.pc_source;
  assign state         = st_q;
  assign instr_done    = retire & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: three controller instances (trap, no-trap, 2-bit counter)
// share one stimulus stream; expected values are hand-derived per step.
module tb_multicycle_controller;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic       clock = 1'b0;
  logic       reset, step_en, mem_ready;
  logic [5:0] opcode;

  logic [2:0] pcw, pcwc, pcwcn, irw, rw, mr, mw, iord, asa, rd, m2r, done, ill;
  logic [2:0] fj, fr, flw, fsw, fbeq;
  logic [1:0] asb [3];
  logic [1:0] aop [3];
  logic [1:0] pcs [3];
  logic [3:0] st  [3];
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int total = 0;
  int bad   = 0;
  int dsum;

  always #5 clock = ~clock;

  multicycle_controller #(.CNT_W(8), .TRAP_ON_ILLEGAL(1'b1), .EXT_EN(1'b1)) u_trap (
    .clock(clock), .reset(reset), .step_en(step_en), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(pcw[0]), .PCWriteCond(pcwc[0]), .PCWriteCondNe(pcwcn[0]), .IRWrite(irw[0]),
    .RegWrite(rw[0]), .MemRead(mr[0]), .MemWrite(mw[0]), .IorD(iord[0]), .ALUSrcA(asa[0]),
    .RegDst(rd[0]), .MemtoReg(m2r[0]), .ALUSrcB(asb[0]), .ALUOp(aop[0]), .PCSource(pcs[0]),
    .state(st[0]), .instr_done(done[0]), .instr_count(cnt0), .illegal(ill[0]),
    .J(fj[0]), .R(fr[0]), .LW(flw[0]), .SW(fsw[0]), .BEQ(fbeq[0]));

  multicycle_controller #(.CNT_W(8), .TRAP_ON_ILLEGAL(1'b0), .EXT_EN(1'b1)) u_skip (
    .clock(clock), .reset(reset), .step_en(step_en), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(pcw[1]), .PCWriteCond(pcwc[1]), .PCWriteCondNe(pcwcn[1]), .IRWrite(irw[1]),
    .RegWrite(rw[1]), .MemRead(mr[1]), .MemWrite(mw[1]), .IorD(iord[1]), .ALUSrcA(asa[1]),
    .RegDst(rd[1]), .MemtoReg(m2r[1]), .ALUSrcB(asb[1]), .ALUOp(aop[1]), .PCSource(pcs[1]),
    .state(st[1]), .instr_done(done[1]), .instr_count(cnt1), .illegal(ill[1]),
    .J(fj[1]), .R(fr[1]), .LW(flw[1]), .SW(fsw[1]), .BEQ(fbeq[1]));

  multicycle_controller #(.CNT_W(2), .TRAP_ON_ILLEGAL(1'b1), .EXT_EN(1'b1)) u_c2 (
    .clock(clock), .reset(reset), .step_en(step_en), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(pcw[2]), .PCWriteCond(pcwc[2]), .PCWriteCondNe(pcwcn[2]), .IRWrite(irw[2]),
    .RegWrite(rw[2]), .MemRead(mr[2]), .MemWrite(mw[2]), .IorD(iord[2]), .ALUSrcA(asa[2]),
    .RegDst(rd[2]), .MemtoReg(m2r[2]), .ALUSrcB(asb[2]), .ALUOp(aop[2]), .PCSource(pcs[2]),
    .state(st[2]), .instr_done(done[2]), .instr_count(cnt2), .illegal(ill[2]),
    .J(fj[2]), .R(fr[2]), .LW(flw[2]), .SW(fsw[2]), .BEQ(fbeq[2]));

  // {PCWrite, PCWriteCond, PCWriteCondNe, IRWrite, RegWrite}
  function automatic logic [4:0] strb(input int i);
    return {pcw[i], pcwc[i], pcwcn[i], irw[i], rw[i]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  logic [3:0] tgl_st [8];
  logic [4:0] tgl_sb [8];
  logic [3:0] lw_st  [5];

  initial begin
    tgl_st = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd6, 4'd6, 4'd7, 4'd7};
    tgl_sb = '{5'b00000, 5'b10010, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001};
    lw_st  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};

    // Reset state
    reset = 1'b1; step_en = 1'b1; mem_ready = 1'b1; opcode = OP_R;
    step(); step();
    chk("rst_state", 32'(st[0]), 32'd0);
    chk("rst_cnt", 32'(cnt0), 32'd0);
    chk("rst_illegal", 32'(ill[0]), 32'd0);
    chk("rst_strobes", 32'(strb(0)), 32'd0);
    chk("rst_memread", 32'(mr[0]), 32'd0);
    chk("rst_alusrcb", 32'(asb[0]), 32'b01);
    chk("rst_flags", 32'({fj[0], fr[0], flw[0], fsw[0], fbeq[0]}), 32'd0);

    // Start lw, then reset in MEM_READ while memory stalls
    reset = 1'b0; opcode = OP_LW; #1;
    chk("fetch_strobes", 32'(strb(0)), 32'b10010);
    chk("fetch_memread", 32'(mr[0]), 32'd1);
    step(); chk("dec_state", 32'(st[0]), 32'd1);
    chk("dec_alusrcb", 32'(asb[0]), 32'b11);
    step(); chk("maddr_state", 32'(st[0]), 32'd2);
    step(); chk("mrd_state", 32'(st[0]), 32'd3);
    chk("mrd_iord", 32'(iord[0]), 32'd1);
    mem_ready = 1'b0; reset = 1'b1; #1;
    chk("rstcyc_memread", 32'(mr[0]), 32'd0);
    chk("rstcyc_regwrite", 32'(rw[0]), 32'd0);
    step();
    reset = 1'b0; #1;
    chk("midrst_state", 32'(st[0]), 32'd0);
    chk("midrst_cnt", 32'(cnt0), 32'd0);
    chk("midrst_memread", 32'(mr[0]), 32'd1);
    chk("midrst_regwrite", 32'(rw[0]), 32'd0);
    chk("fetch_stall_pcwrite", 32'(pcw[0]), 32'd0);
    chk("midrst_lwflag", 32'(flw[0]), 32'd0);

    // lw with mem_ready held high: 5 cycles
    mem_ready = 1'b1; #1;
    dsum = 0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("lw_state%0d", k), 32'(st[0]), 32'(lw_st[k]));
      if (k == 4) begin
        chk("lw_regwrite", 32'(rw[0]), 32'd1);
        chk("lw_memtoreg", 32'(m2r[0]), 32'd1);
      end
      dsum += 32'(done[0]);
      step();
    end
    chk("lw_done_pulses", 32'(dsum), 32'd1);
    chk("lw_cnt", 32'(cnt0), 32'd1);
    chk("lw_back_fetch", 32'(st[0]), 32'd0);
    chk("lw_flag", 32'(flw[0]), 32'd1);

    // sw with three wait cycles in MEM_WRITE: 7 cycles
    opcode = OP_SW; #1;
    step(); step(); step();
    chk("sw_state_arr", 32'(st[0]), 32'd5);
    mem_ready = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("sw_wait_state%0d", k), 32'(st[0]), 32'd5);
      chk($sformatf("sw_wait_memwrite%0d", k), 32'(mw[0]), 32'd1);
      chk($sformatf("sw_wait_done%0d", k), 32'(done[0]), 32'd0);
      step();
    end
    mem_ready = 1'b1; #1;
    chk("sw_last_state", 32'(st[0]), 32'd5);
    chk("sw_last_memwrite", 32'(mw[0]), 32'd1);
    chk("sw_done", 32'(done[0]), 32'd1);
    step();
    chk("sw_back_fetch", 32'(st[0]), 32'd0);
    chk("sw_cnt", 32'(cnt0), 32'd2);
    chk("sw_memwrite_off", 32'(mw[0]), 32'd0);
    chk("sw_flag", 32'(fsw[0]), 32'd1);

    // beq, bne, j, addi, R from a fresh count
    do_reset();
    opcode = OP_BEQ; #1;
    step(); chk("beq_dec", 32'(st[0]), 32'd1);
    step(); chk("beq_state", 32'(st[0]), 32'd8);
    chk("beq_strobes", 32'(strb(0)), 32'b01000);
    chk("beq_pcsource", 32'(pcs[0]), 32'b01);
    chk("beq_aluop", 32'(aop[0]), 32'b01);
    chk("beq_flag", 32'(fbeq[0]), 32'd1);
    step(); chk("beq_cnt2", 32'(cnt2), 32'd1);

    opcode = OP_BNE; #1;
    step(); step();
    chk("bne_state", 32'(st[0]), 32'd8);
    chk("bne_strobes", 32'(strb(0)), 32'b00100);
    chk("bne_flag", 32'(fbeq[0]), 32'd1);
    step(); chk("bne_cnt2", 32'(cnt2), 32'd2);

    opcode = OP_J; #1;
    step(); step();
    chk("j_state", 32'(st[0]), 32'd9);
    chk("j_strobes", 32'(strb(0)), 32'b10000);
    chk("j_pcsource", 32'(pcs[0]), 32'b10);
    chk("j_flag", 32'(fj[0]), 32'd1);
    step(); chk("j_cnt2", 32'(cnt2), 32'd3);

    opcode = OP_ADDI; #1;
    step(); step();
    chk("addi_exec_state", 32'(st[0]), 32'd10);
    chk("addi_alusrcb", 32'(asb[0]), 32'b10);
    step();
    chk("addi_wb_state", 32'(st[0]), 32'd11);
    chk("addi_regdst", 32'(rd[0]), 32'd0);
    chk("addi_strobes", 32'(strb(0)), 32'b00001);
    chk("addi_memtoreg", 32'(m2r[0]), 32'd0);
    step(); chk("addi_cnt2_wrap", 32'(cnt2), 32'd0);

    opcode = OP_R; #1;
    step(); step();
    chk("r_exec_state", 32'(st[0]), 32'd6);
    chk("r_aluop", 32'(aop[0]), 32'b10);
    step();
    chk("r_wb_state", 32'(st[0]), 32'd7);
    chk("r_regdst", 32'(rd[0]), 32'd1);
    chk("r_strobes", 32'(strb(0)), 32'b00001);
    chk("r_flag", 32'(fr[0]), 32'd1);
    step();
    chk("seq_cnt", 32'(cnt0), 32'd5);
    chk("seq_cnt2", 32'(cnt2), 32'd1);

    // R with step_en toggling, starting low: 8 cycles
    opcode = OP_R;
    for (int k = 0; k < 8; k++) begin
      step_en = ((k % 2) == 1); #1;
      chk($sformatf("tgl_state%0d", k), 32'(st[0]), 32'(tgl_st[k]));
      chk($sformatf("tgl_strobes%0d", k), 32'(strb(0)), 32'(tgl_sb[k]));
      if (k == 0) chk("tgl_memread_hold", 32'(mr[0]), 32'd1);
      if (k == 6) chk("tgl_done_gated", 32'(done[0]), 32'd0);
      if (k == 7) chk("tgl_done", 32'(done[0]), 32'd1);
      step();
    end
    step_en = 1'b1; #1;
    chk("tgl_back_fetch", 32'(st[0]), 32'd0);
    chk("tgl_cnt", 32'(cnt0), 32'd6);
    chk("tgl_cnt2", 32'(cnt2), 32'd2);

    // Illegal opcode: trapping vs skipping instance
    opcode = OP_BAD; #1;
    step(); step();
    chk("ill_state_trap", 32'(st[0]), 32'd12);
    chk("ill_flag_trap", 32'(ill[0]), 32'd1);
    chk("ill_state_skip", 32'(st[1]), 32'd12);
    chk("ill_flag_skip", 32'(ill[1]), 32'd1);
    chk("ill_flags_clear", 32'({fj[0], fr[0], flw[0], fsw[0], fbeq[0]}), 32'd0);
    step();
    chk("skip_back_fetch", 32'(st[1]), 32'd0);
    chk("skip_cnt", 32'(cnt1), 32'd6);
    chk("skip_flag_sticky", 32'(ill[1]), 32'd1);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("trap_hold%0d", k), 32'(st[0]), 32'd12);
      chk($sformatf("trap_strobes%0d", k), 32'(strb(0)), 32'd0);
      step();
    end
    chk("trap_cnt", 32'(cnt0), 32'd6);
    chk("trap_flag", 32'(ill[0]), 32'd1);

    do_reset();
    chk("final_illegal", 32'(ill[0]), 32'd0);
    chk("final_state", 32'(st[0]), 32'd0);
    chk("final_cnt", 32'(cnt0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
